// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-side memory controller and the 512x32 main memory.
package mem_pkg;
  localparam int MEM_AW    = 9;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
endpackage

// File: rtl/mem_ctrl.sv
// Request/ack controller driving main memory; latches a request, holds it WAIT_CYCLES, then acks.
// Optional feature: MEM_CTRL_BOUNDS_CHECK_EN flags and suppresses accesses with addr >= 2**MEM_AW.
module mem_ctrl #(
  parameter int DATA_W      = mem_pkg::DATA_W,
  parameter int MEM_AW      = mem_pkg::MEM_AW,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);
  import mem_pkg::*;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       we_q;
  logic       oor_q;
  logic       oor;

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  assign oor = |addr[31:MEM_AW];
`else
  logic unused_hi;
  assign unused_hi = ^addr[31:MEM_AW];
  assign oor       = 1'b0;
`endif

  // mem_we is registered, so it is raised on the edge that enters the final ACCESS cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            we_q     <= we;
            oor_q    <= oor;
            mem_addr <= addr[MEM_AW-1:0];
            mem_din  <= wdata;
            cnt_q    <= CNT_INIT;
            busy     <= 1'b1;
            mem_we   <= we && !oor && (CNT_INIT == 4'd0);
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            mem_we  <= 1'b0;
            if (!we_q) rdata <= oor_q ? '0 : mem_dout;
            ack     <= 1'b1;
            err     <= oor_q;
            state_q <= DONE;
          end else begin
            cnt_q  <= cnt_q - 4'd1;
            mem_we <= we_q && !oor_q && (cnt_q == 4'd1);
          end
        end
        DONE: begin
          ack     <= 1'b0;
          busy    <= 1'b0;
          err     <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench: three controllers (WAIT_CYCLES 1/4/3) each on a behavioural 512x32 memory, checked against a reference.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        req_a [3];
  logic        we_a [3];
  logic [31:0] addr_a [3];
  logic [31:0] wdata_a [3];
  logic        ack_a [3];
  logic [31:0] rdata_a [3];
  logic        busy_a [3];
  logic        err_a [3];
  logic [8:0]  mem_addr_a [3];
  logic [31:0] mem_din_a [3];
  logic        mem_we_a [3];
  logic [31:0] mem_dout_a [3];

  int errors = 0;
  int checks = 0;

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic int wc(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 3);
  endfunction

  function automatic logic [31:0] init_val(input int d, input int k);
    return 32'hA500_0000 ^ (32'(d) << 20) ^ (32'(k) * 32'd40503);
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g
    localparam int W = (i == 0) ? 1 : ((i == 1) ? 4 : 3);
    logic [31:0] m [512];
    logic        loaded = 1'b0;

    mem_ctrl #(.DATA_W(32), .MEM_AW(9), .WAIT_CYCLES(W)) dut (
      .clk(clk), .clr_n(clr_n), .req(req_a[i]), .we(we_a[i]), .addr(addr_a[i]),
      .wdata(wdata_a[i]), .ack(ack_a[i]), .rdata(rdata_a[i]), .busy(busy_a[i]),
      .err(err_a[i]), .mem_addr(mem_addr_a[i]), .mem_din(mem_din_a[i]),
      .mem_we(mem_we_a[i]), .mem_dout(mem_dout_a[i])
    );

    always @(posedge clk) begin
      if (!loaded) begin
        for (int k = 0; k < 512; k++) m[k] <= init_val(i, k);
        loaded <= 1'b1;
      end else if (mem_we_a[i]) begin
        m[mem_addr_a[i]] <= mem_din_a[i];
      end
    end
    assign mem_dout_a[i] = m[mem_addr_a[i]];
  end

  // Reference: writes that the memory should have seen, keyed by instance*512 + word.
  logic [31:0] refw [int];
  logic [31:0] last_rd [3];

  function automatic logic [31:0] ref_read(input int d, input int w);
    int key;
    key = d * 512 + w;
    return refw.exists(key) ? refw[key] : init_val(d, w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
    int          wt, ack_cyc, busy_cnt, we_cnt, word;
    bit          oor, addr_ok, din_ok;
    logic [31:0] exp_rd;
    wt      = wc(d);
    oor     = BC && (a >= 32'd512);
    word    = int'(a % 32'd512);
    exp_rd  = w ? last_rd[d] : (oor ? 32'h0 : ref_read(d, word));
    ack_cyc = 0; busy_cnt = 0; we_cnt = 0; addr_ok = 1'b1; din_ok = 1'b1;
    req_a[d] = 1'b1; we_a[d] = w; addr_a[d] = a; wdata_a[d] = wd;
    for (int c = 1; c <= 40 && ack_cyc == 0; c++) begin
      @(negedge clk);
      if (busy_a[d]) busy_cnt++;
      if (mem_addr_a[d] !== 9'(word)) addr_ok = 1'b0;
      if (w && mem_din_a[d] !== wd) din_ok = 1'b0;
      if (mem_we_a[d]) we_cnt++;
      if (ack_a[d] === 1'b1) begin
        ack_cyc = c;
        check("rdata", rdata_a[d], exp_rd);
        check("err", 32'(err_a[d]), 32'(oor));
      end
      if (c == 1) begin
        req_a[d] = 1'b0; we_a[d] = ~w; addr_a[d] = $urandom; wdata_a[d] = $urandom;
      end
    end
    check("ack_latency", ack_cyc, wt + 1);
    check("busy_cycles", busy_cnt, wt + 1);
    check("we_pulses", we_cnt, (w && !oor) ? 1 : 0);
    check("addr_stable", 32'(addr_ok), 32'd1);
    if (w) check("din_stable", 32'(din_ok), 32'd1);
    @(negedge clk);
    check("idle_after", {29'h0, busy_a[d], ack_a[d], mem_we_a[d]}, 32'h0);
    if (w && !oor) refw[d * 512 + word] = wd;
    if (!w) last_rd[d] = exp_rd;
  endtask

  task automatic check_reset(input int d);
    check("rst_ack", 32'(ack_a[d]), 32'h0);
    check("rst_busy", 32'(busy_a[d]), 32'h0);
    check("rst_err", 32'(err_a[d]), 32'h0);
    check("rst_rdata", rdata_a[d], 32'h0);
    check("rst_maddr", 32'(mem_addr_a[d]), 32'h0);
    check("rst_mdin", mem_din_a[d], 32'h0);
    check("rst_mwe", 32'(mem_we_a[d]), 32'h0);
  endtask

  initial begin
    int acks;
    for (int d = 0; d < 3; d++) begin
      req_a[d] = 1'b0; we_a[d] = 1'b0; addr_a[d] = '0; wdata_a[d] = '0; last_rd[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset(d);
    clr_n = 1'b1;

    // Idle with req low: no ack anywhere.
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (ack_a[d] || busy_a[d]) acks++;
    end
    check("idle_no_ack", acks, 0);

    access(0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF);
    access(0, 1'b0, 32'h0000_0005, 32'h0);
    access(1, 1'b0, 32'h0000_0033, 32'h0);
    access(0, 1'b1, 32'h0000_0007, 32'h1234_5678);
    access(0, 1'b0, 32'h0000_0007, 32'h0);

    // Out-of-range write/read: suppressed with bounds check, wraps to word 5 / 0 without.
    access(0, 1'b1, 32'h0000_0205, 32'hCAFE_F00D);
    access(0, 1'b0, 32'h0000_0005, 32'h0);
    access(0, 1'b0, 32'h8000_0000, 32'h0);
    access(0, 1'b1, 32'h0000_0003, 32'h0BAD_0003);

    // Reset in the first ACCESS cycle of a 3-wait write: nothing written, no ack.
    @(negedge clk);
    req_a[2] = 1'b1; we_a[2] = 1'b1; addr_a[2] = 32'd9; wdata_a[2] = 32'h1111_2222;
    @(negedge clk);
    req_a[2] = 1'b0;
    clr_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_reset(d);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    for (int d = 0; d < 3; d++) last_rd[d] = '0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack_a[2] || mem_we_a[2] || busy_a[2]) acks++;
    end
    check("post_rst_quiet", acks, 0);
    access(2, 1'b0, 32'd9, 32'h0);
    access(2, 1'b1, 32'd9, 32'h3333_4444);
    access(2, 1'b0, 32'd9, 32'h0);

    for (int n = 0; n < 40; n++) begin
      int          d;
      bit          w;
      logic [31:0] a;
      d = int'($urandom_range(0, 2));
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
      access(d, w, a, 32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
